// File: rtl/conv_pkg.sv
// Shared widths and types for the 3x3 convolution window controller and its datapath.
package conv_pkg;
  localparam int PIX_W    = 8;
  localparam int DP_IN_W  = 9;
  localparam int DP_OUT_W = 21;

  typedef logic signed [DP_IN_W-1:0] dp_pix_t;
  typedef dp_pix_t [0:2][0:2] window_t;

  typedef logic signed [7:0] coef_elem_t;
  typedef coef_elem_t [0:2][0:2] coef_t;
endpackage

// File: rtl/conv_window_ctrl_line_buffer.sv
// Two-line pixel history addressed by column: combinational read, and on write the
// column shifts down one line (line 1 takes line 0, line 0 takes the new pixel).
module line_buffer #(
  parameter int DEPTH = 640,
  parameter int W     = 8,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  lb0_o,
  output logic [W-1:0]  lb1_o
);
  logic [W-1:0] lb0_q [DEPTH];
  logic [W-1:0] lb1_q [DEPTH];

  assign lb0_o = lb0_q[addr_i];
  assign lb1_o = lb1_q[addr_i];

  // Contents are never cleared: the first two rows of a frame never reach the output.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      lb1_q[addr_i] <= lb0_q[addr_i];
      lb0_q[addr_i] <= din_i;
    end
  end
endmodule

// File: rtl/conv_window_ctrl.sv
// Streaming front end of the 3x3 convolution: raster counters, line buffers, 3x3 window
// and a valid/ready result stream aligned with the datapath's one-cycle registered output.
module conv_window_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = conv_pkg::PIX_W
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [PIX_W-1:0]  pix_in_i,
  input  logic              pix_valid_i,
  output logic              pix_ready_o,
  output conv_pkg::window_t win_o,
  output logic              dp_stall_o,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic              res_last_o,
  output logic              frame_done_o,
  output logic              busy_o
);
  import conv_pkg::*;

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  window_t          win_q, win_d;
  logic             win_valid_q, win_valid_d;
  logic             win_last_q, win_last_d;
  logic             res_valid_q, res_valid_d;
  logic             res_last_q, res_last_d;
  logic             frame_done_q, frame_done_d;
  logic [PIX_W-1:0] lb0_rd, lb1_rd;
  logic             hold;
  logic             acc;

  // A result waiting on the consumer freezes the whole pipeline, datapath included.
  assign hold        = res_valid_q & ~res_ready_i;
  assign pix_ready_o = ~hold & ~reset_i;
  assign acc         = pix_valid_i & pix_ready_o;

  line_buffer #(
    .DEPTH (IMG_W),
    .W     (PIX_W)
  ) u_line_buffer (
    .clk_i  (clk_i),
    .we_i   (acc),
    .addr_i (col_q),
    .din_i  (pix_in_i),
    .lb0_o  (lb0_rd),
    .lb1_o  (lb1_rd)
  );

  // Next-state: window shift and raster counters on accept, pipeline flags when not held.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    win_valid_d  = win_valid_q;
    win_last_d   = win_last_q;
    res_valid_d  = res_valid_q;
    res_last_d   = res_last_q;
    frame_done_d = res_valid_q & res_ready_i & res_last_q;

    if (acc) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = dp_pix_t'(lb1_rd);
      win_d[1][2] = dp_pix_t'(lb0_rd);
      win_d[2][2] = dp_pix_t'(pix_in_i);
      if (col_q == COL_MAX) begin
        col_d = '0;
        if (row_q == ROW_MAX) begin
          row_d = '0;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end else begin
      win_d = win_q;
    end

    // Window validity uses the counters of the pixel being accepted, before they advance.
    if (!hold) begin
      win_valid_d = acc & (row_q >= RW'(2)) & (col_q >= CW'(2));
      win_last_d  = acc & (row_q == ROW_MAX) & (col_q == COL_MAX);
      res_valid_d = win_valid_q;
      res_last_d  = win_last_q;
    end else begin
      win_valid_d = win_valid_q;
      win_last_d  = win_last_q;
      res_valid_d = res_valid_q;
      res_last_d  = res_last_q;
    end
  end

  // State registers with synchronous reset; a reset mid-frame simply abandons the frame.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      win_last_q   <= 1'b0;
      res_valid_q  <= 1'b0;
      res_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      win_valid_q  <= win_valid_d;
      win_last_q   <= win_last_d;
      res_valid_q  <= res_valid_d;
      res_last_q   <= res_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign win_o        = win_q;
  assign dp_stall_o   = hold;
  assign res_valid_o  = res_valid_q;
  assign res_last_o   = res_last_q;
  assign frame_done_o = frame_done_q;
  assign busy_o       = (col_q != '0) | (row_q != '0) | win_valid_q | res_valid_q;
endmodule
